// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: serves one 256-bit cache line request as a 4-beat 64-bit memory burst.
// Address and write line are captured at acceptance; each finished line gets a one-cycle pmem_resp.
module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    input  logic         pmem_read,
    input  logic         pmem_write,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic [31:0]  burst_address,
    output logic         burst_read,
    output logic         burst_write,
    output logic [63:0]  burst_wdata,
    input  logic [63:0]  burst_rdata,
    input  logic         burst_resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic [26:0]  addr_q, addr_d;
    logic [255:0] wline_q, wline_d;
    logic [255:0] rline_q, rline_d;
    logic [63:0]  wdata_q, wdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            addr_q  <= 27'd0;
            wline_q <= 256'd0;
            rline_q <= 256'd0;
            wdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            wdata_q <= wdata_d;
        end
    end

    // burst_wdata is preloaded with the next beat whenever a write beat is accepted,
    // so the memory side always sees a registered value held through stalls.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        wline_d     = wline_q;
        rline_d     = rline_q;
        wdata_d     = wdata_q;
        burst_read  = 1'b0;
        burst_write = 1'b0;
        pmem_resp   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    addr_d  = pmem_address[31:5];
                    wline_d = pmem_wdata;
                    wdata_d = pmem_wdata[63:0];
                    beat_d  = 2'd0;
                    state_d = WRITE;
                end else if (pmem_read) begin
                    addr_d  = pmem_address[31:5];
                    beat_d  = 2'd0;
                    state_d = READ;
                end
            end

            READ: begin
                burst_read = 1'b1;
                if (burst_resp) begin
                    rline_d[{beat_q, 6'd0} +: 64] = burst_rdata;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end

            WRITE: begin
                burst_write = 1'b1;
                if (burst_resp) begin
                    beat_d  = beat_q + 2'd1;
                    wdata_d = wline_q[{beat_d, 6'd0} +: 64];
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                pmem_resp = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pmem_rdata    = rline_q;
    assign burst_address = {addr_q, 5'd0};
    assign burst_wdata   = wdata_q;

endmodule
